// File: rtl/mips_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, mode codes and the CTRL field layout.
package mips_timer_pkg;

    // Timer sequencing states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Word offsets within the device window (bus address[3:2])
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESET = 2'd1,
        REG_COUNT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    // CTRL.MODE codes; 2'b1x decodes as one-shot
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_AUTO    = 2'b01
    } timer_mode_e;

    // CTRL bit positions, mirroring the coprocessor field macros
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM_BIT  = 3;
    localparam int unsigned CTRL_WIDTH   = 4;

    // Packed view of CTRL[3:0]: IM, MODE[1:0], EN (MSB first)
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    // Only the exact auto-reload code selects reload; everything else is one-shot
    function automatic logic mode_is_auto(input logic [1:0] mode);
        return (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/mips_timer_if.sv
// System-bridge slave port for the timer: decoded write strobe, word offset,
// write data and combinational read data.
interface mips_timer_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // Bridge side drives the request and samples read data
    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    // Device side consumes the request and returns read data
    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer: one-shot (irq held until CTRL is rewritten)
// or auto-reload (one-cycle irq pulse every PRESET+2 cycles).
module mips_timer
    import mips_timer_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    mips_timer_if.slave   bus,
    output logic          irq
);

    timer_state_e state;
    ctrl_t        ctrl;
    logic [31:0]  preset;
    logic [31:0]  count;
    logic         irq_flag;

    logic         ctrl_wr;
    logic         preset_wr;
    logic         expire;
    logic         int_oneshot;
    logic         int_reload;
    logic         flag_set;
    logic         flag_clr;

    // Decode bus writes and the FSM events that touch CTRL and irq_flag
    always_comb begin
        ctrl_wr     = 1'b0;
        preset_wr   = 1'b0;
        expire      = 1'b0;
        int_oneshot = 1'b0;
        int_reload  = 1'b0;
        if (bus.we) begin
            ctrl_wr   = (reg_addr_e'(bus.addr) == REG_CTRL);
            preset_wr = (reg_addr_e'(bus.addr) == REG_PRESET);
        end
        if (state == ST_CNT && ctrl.en && count <= 32'd1) begin
            expire = 1'b1;
        end
        if (state == ST_INT) begin
            int_reload  = mode_is_auto(ctrl.mode);
            int_oneshot = ~mode_is_auto(ctrl.mode);
        end
        // Expiry set outranks any clear landing in the same cycle
        flag_set = expire;
        flag_clr = ctrl_wr | int_reload;
    end

    // Timer state, count, control and interrupt flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            preset   <= RESET_PRESET;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ctrl.en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl.en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (int_reload) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A CTRL write overrides the one-shot EN self-clear
            if (ctrl_wr) begin
                ctrl <= ctrl_t'(bus.wdata[CTRL_WIDTH-1:0]);
            end else if (int_oneshot) begin
                ctrl.en <= 1'b0;
            end

            if (preset_wr) begin
                preset <= bus.wdata;
            end

            if (flag_set) begin
                irq_flag <= 1'b1;
            end else if (flag_clr) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Register read mux
    always_comb begin
        bus.rdata = '0;
        unique case (reg_addr_e'(bus.addr))
            REG_CTRL:   bus.rdata = {{(32-CTRL_WIDTH){1'b0}}, ctrl};
            REG_PRESET: bus.rdata = preset;
            REG_COUNT:  bus.rdata = count;
            REG_RSVD:   bus.rdata = '0;
            default:    bus.rdata = '0;
        endcase
    end

    assign irq = irq_flag & ctrl.im;

endmodule

// File: tb/tb_mips_timer.sv
// Directed self-checking bench for mips_timer. All steps run from edge+1ns;
// edge numbers in comments count from the write edge E0 that sets CTRL.EN.
module tb_mips_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        irq;
    logic [31:0] rv;
    int          tests = 0;
    int          fails = 0;

    mips_timer_if bus();

    mips_timer #(.RESET_PRESET(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus.addr = a;
        #1;
        v = bus.rdata;
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;

        // Reset held, then released
        #12;
        check("irq_in_reset", {31'b0, irq}, 32'h0);
        #10 reset = 1'b1;
        tick(1);
        check_reg("rst_ctrl", 2'd0, 32'h0);
        check_reg("rst_preset", 2'd1, 32'h0);
        check_reg("rst_count", 2'd2, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // COUNT/reserved writes ignored, CTRL upper bits read zero
        write_reg(2'd2, 32'h0000_1234);
        check_reg("count_ro", 2'd2, 32'h0);
        write_reg(2'd3, 32'hFFFF_FFFF);
        check_reg("rsvd_zero", 2'd3, 32'h0);
        write_reg(2'd0, 32'hFFFF_FFF8);
        check_reg("ctrl_upper", 2'd0, 32'h8);
        write_reg(2'd0, 32'h0);

        // One-shot, PRESET=5
        write_reg(2'd1, 32'd5);
        write_reg(2'd0, 32'h9);                 // E0
        tick(2);                                 // E2
        check_reg("os_count5", 2'd2, 32'd5);
        tick(4);                                 // E6
        check_reg("os_count1", 2'd2, 32'd1);
        check("os_irq_e6", {31'b0, irq}, 32'h0);
        tick(1);                                 // E7
        check("os_irq_e7", {31'b0, irq}, 32'h1);
        tick(1);                                 // E8
        check_reg("os_ctrl_en_clr", 2'd0, 32'h8);
        tick(3);
        check("os_irq_held", {31'b0, irq}, 32'h1);
        write_reg(2'd0, 32'h0);
        check("os_ack", {31'b0, irq}, 32'h0);

        // MODE=2'b10 behaves as one-shot, PRESET=1
        write_reg(2'd1, 32'd1);
        write_reg(2'd0, 32'hD);                 // E0
        tick(3);                                 // E3
        check("m10_irq_e3", {31'b0, irq}, 32'h1);
        tick(1);                                 // E4
        check_reg("m10_ctrl", 2'd0, 32'hC);
        check("m10_irq_held", {31'b0, irq}, 32'h1);
        write_reg(2'd0, 32'h0);
        check("m10_ack", {31'b0, irq}, 32'h0);

        // Auto-reload, PRESET=3: irq pulses at E5, E10, E15
        write_reg(2'd1, 32'd3);
        write_reg(2'd0, 32'hB);                 // E0
        for (int k = 1; k <= 16; k++) begin
            int j;
            logic [31:0] ec;
            tick(1);
            check("ar_irq", {31'b0, irq}, (k % 5 == 0) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                j  = (k - 2) % 5;
                ec = (j == 0) ? 32'd3 : (j == 1) ? 32'd2 : (j == 2) ? 32'd1 : 32'd0;
                check_reg("ar_count", 2'd2, ec);
            end
        end
        // EN cleared while in LOAD: COUNT still loads, then CNT drops to IDLE
        write_reg(2'd0, 32'h0);                 // E17
        tick(3);
        check_reg("ar_stop_count", 2'd2, 32'd3);
        check("ar_stop_irq", {31'b0, irq}, 32'h0);

        // Mask: PRESET=2, IM=0
        write_reg(2'd1, 32'd2);
        write_reg(2'd0, 32'h1);                 // E0
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("mask_irq", {31'b0, irq}, 32'h0);
        end
        check_reg("mask_ctrl", 2'd0, 32'h0);
        write_reg(2'd0, 32'h8);
        check("mask_unmask", {31'b0, irq}, 32'h0);
        tick(1);
        check("mask_unmask2", {31'b0, irq}, 32'h0);

        // Stop mid-count: COUNT holds 10
        write_reg(2'd1, 32'd20);
        write_reg(2'd0, 32'h9);                 // E0
        tick(11);                                // E11
        check_reg("stop_c11", 2'd2, 32'd11);
        write_reg(2'd0, 32'h0);                 // E12
        check_reg("stop_c10", 2'd2, 32'd10);
        tick(3);
        check_reg("stop_hold", 2'd2, 32'd10);
        check("stop_irq", {31'b0, irq}, 32'h0);

        // PRESET rewritten mid-count, effective only at the next LOAD
        write_reg(2'd1, 32'd7);
        write_reg(2'd0, 32'h9);                 // E0
        tick(2);
        check_reg("pm_c7", 2'd2, 32'd7);
        tick(1);
        write_reg(2'd1, 32'd3);                 // E4
        check_reg("pm_c5", 2'd2, 32'd5);
        check_reg("pm_preset", 2'd1, 32'd3);
        tick(4);                                 // E8
        check_reg("pm_c1", 2'd2, 32'd1);
        check("pm_irq_e8", {31'b0, irq}, 32'h0);
        tick(1);                                 // E9
        check("pm_irq_e9", {31'b0, irq}, 32'h1);
        tick(1);                                 // E10 -> IDLE
        write_reg(2'd0, 32'h9);                 // restart E0'
        check("pm_ack", {31'b0, irq}, 32'h0);
        tick(2);
        check_reg("pm_reload3", 2'd2, 32'd3);
        write_reg(2'd0, 32'h0);
        tick(1);

        // PRESET=0 behaves as 1: irq at E3
        write_reg(2'd1, 32'd0);
        write_reg(2'd0, 32'h9);                 // E0
        tick(2);                                 // E2
        check("p0_irq_e2", {31'b0, irq}, 32'h0);
        check_reg("p0_count", 2'd2, 32'd0);
        tick(1);                                 // E3
        check("p0_irq_e3", {31'b0, irq}, 32'h1);

        // Collision: CTRL write lands on the one-shot INT edge
        write_reg(2'd0, 32'h9);                 // E4
        check_reg("col_ctrl", 2'd0, 32'h9);
        check("col_irq", {31'b0, irq}, 32'h0);
        tick(2);                                 // E6
        check("col_irq_e6", {31'b0, irq}, 32'h0);
        tick(1);                                 // E7
        check("col_restart", {31'b0, irq}, 32'h1);

        // Asynchronous reset with irq high
        #2 reset = 1'b0;
        #1;
        check("arst_irq", {31'b0, irq}, 32'h0);
        check_reg("arst_count", 2'd2, 32'h0);
        check_reg("arst_ctrl", 2'd0, 32'h0);
        check_reg("arst_preset", 2'd1, 32'h0);
        #10 reset = 1'b1;
        tick(2);
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped countdown timer on the P7 system bridge.
- Produces one of the device interrupt lines that the coprocessor samples into Cause.IP each cycle through HWInt.
- The CPU programs it with sw, reads it with lw, and acknowledges its interrupt from the handler by rewriting CTRL.
- Two modes: one-shot (interrupt held until acknowledged) and auto-reload (one-cycle interrupt pulse every period).

Parameters:
- RESET_PRESET, 32'h0000_0000, value loaded into PRESET on reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous reset, active-low (asserted when 0), clears all state immediately.
- addr  in  2  word offset from bus address[3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- we  in  1  bus write enable for this device (bridge has already decoded the address range).
- wdata  in  32  bus write data.
- rdata  out  32  combinational read data for the current addr.
- irq  out  1  interrupt request, routed to one HWInt bit.

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = allow). CTRL[31:4] always read 0.
  - PRESET[31:0]: reload value.
  - COUNT[31:0]: current count, read-only; writes to addr 2 and addr 3 are ignored.
  - Internal irq_flag bit.
- Reset values: CTRL = 0, PRESET = RESET_PRESET, COUNT = 0, irq_flag = 0, state = IDLE. Outputs: irq = 0, rdata = 0 when addr = 0.
- rdata, combinational:
  - addr 0 -> {28'b0, CTRL}
  - addr 1 -> PRESET
  - addr 2 -> COUNT
  - addr 3 -> 0
- irq = irq_flag & CTRL.IM. It is registered-derived, with no combinational path from the bus.
- Bus writes (posedge, we = 1):
  - addr 0: CTRL <= wdata[3:0] and irq_flag <= 0. This is the acknowledge.
  - addr 1: PRESET <= wdata. Does not disturb a count in progress; takes effect at the next LOAD.
- State machine, encoded in 2 bits:
  - IDLE: irq_flag unchanged. If CTRL.EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If CTRL.EN = 0: go to IDLE; COUNT holds.
    - Else if COUNT > 1: COUNT <= COUNT - 1.
    - Else (COUNT of 0 or 1): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE one-shot: CTRL.EN <= 0, go to IDLE. irq_flag stays 1 until a CTRL write.
  - INT, MODE auto-reload: irq_flag <= 0, go to LOAD.
- Latency:
  - Write of CTRL.EN = 1 at edge E0 -> LOAD at E1 -> COUNT = P at E2.
  - irq_flag rises at edge E0 + P + 2 for P >= 1; P = 0 behaves as P = 1.
  - Auto-reload repeats every P + 2 cycles with irq high for exactly 1 cycle.
- Simultaneous events:
  - A CTRL write in the same cycle as INT's EN clear: the written value wins. The state machine still moves to IDLE, and irq_flag ends 0.
  - A CTRL write in the same cycle irq_flag would be set: irq_flag ends 1, because the set wins over the clear from the write.
  - EN cleared by write during LOAD: COUNT loads, then CNT sees EN = 0 -> IDLE.
- Arithmetic: COUNT decrement is unsigned 32-bit and never wraps below 0.
- Reset mid-count: all registers go to their reset values asynchronously; irq drops in the same cycle reset asserts.

Decomposition:
- def.v gains:
  - timer state encodings: IDLE 2'd0, LOAD 2'd1, CNT 2'd2, INT 2'd3.
  - register offsets: CTRL 2'd0, PRESET 2'd1, COUNT 2'd2.
  - mode codes.
  - CTRL bit positions EN/MODE/IM as macros, matching the coprocessor's SR/Cause field macros.
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset: hold reset = 0, then release -> CTRL = 0, COUNT = 0, PRESET = 0, irq = 0. Assert reset = 0 mid-count with irq high -> irq = 0 immediately, rdata@addr2 = 0.
- One-shot: write PRESET = 5, then CTRL = 4'b1001 at E0 -> COUNT reads 5 after E2, 1 after E6. irq rises at E7 and stays high, CTRL reads 4'b1000. Write CTRL = 0 -> irq low next cycle.
- Auto-reload: PRESET = 3, CTRL = 4'b1011 -> irq is a 1-cycle pulse at E5, E10, E15 (period 5). COUNT sequence 3, 2, 1, 0, 3, …
- Mask: PRESET = 2, CTRL = 4'b0001 -> irq stays 0 while CTRL.EN self-clears at expiry. Rewriting CTRL = 4'b1000 leaves irq low, because the write acknowledges the pending flag.
- Stop/edge: during CNT with COUNT = 10, write CTRL = 0 -> next cycle IDLE, COUNT holds 10, no irq. PRESET = 0 with EN = 1 -> irq at E3. PRESET written mid-count does not change COUNT until the next LOAD.
- Collision: one-shot INT cycle coincides with a CTRL = 4'b1001 write -> CTRL reads 4'b1001 afterwards, irq = 0, and the timer restarts via LOAD.
